// File: rtl/transmissor_paridade_pkg.sv
// Shared definitions for the parity transmitter and its matching display decoder.
// Both ends call paridade_par so that they agree on the parity bit.
package pacote_paridade;

  localparam int LARG_COD     = 5;
  localparam int LARG_PALAVRA = LARG_COD + 1;
  localparam int COD_MAX      = 19;

  typedef enum logic [1:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARADA
  } estado_t;

  function automatic logic paridade_par(input logic [LARG_COD-1:0] codigo);
    return ^codigo;
  endfunction

endpackage

// File: rtl/transmissor_paridade_divisor_bit.sv
// Bit-period divider: counts 0..CICLOS_POR_BIT-1 and pulses tick on the last count.
// tick_antes marks the count just before tick, so the stop bit can end a cycle early.
module divisor_bit #(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic limpa,
  output logic tick,
  output logic tick_antes
);

  localparam int LARG_CNT = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [LARG_CNT-1:0] CNT_ULT = LARG_CNT'(CICLOS_POR_BIT - 1);
  localparam logic [LARG_CNT-1:0] CNT_PEN =
    (CICLOS_POR_BIT > 1) ? LARG_CNT'(CICLOS_POR_BIT - 2) : '0;

  logic [LARG_CNT-1:0] contagem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem <= '0;
    end else if (limpa || tick) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + 1'b1;
    end
  end

  assign tick       = (contagem == CNT_ULT);
  assign tick_antes = (CICLOS_POR_BIT > 1) && (contagem == CNT_PEN);

endmodule

// File: rtl/transmissor_paridade.sv
// Accepts a character code, appends even parity (optionally corrupted), and presents
// the word in parallel and as a start/stop framed serial stream, MSB first.
//
// estado | meaning
// OCIOSO | line idle high, ready to accept a code
// INICIO | start bit (0)
// DADOS  | word bits palavra[5] down to palavra[0]
// PARADA | stop bit (1); the final stop cycle is spent back in OCIOSO
module transmissor_paridade #(
  parameter int LARG_COD       = pacote_paridade::LARG_COD,
  parameter int COD_MAX        = pacote_paridade::COD_MAX,
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LARG_COD-1:0] codigo,
  input  logic                valido,
  input  logic                injeta_erro,
  output logic                pronto,
  output logic [LARG_COD:0]   palavra,
  output logic                palavra_valida,
  output logic                codigo_invalido,
  output logic                serial,
  output logic                ocupado
);

  import pacote_paridade::*;

  localparam int LARG_BIT = $clog2(LARG_COD + 1);
  localparam logic [LARG_BIT-1:0] ULT_BIT = LARG_BIT'(LARG_COD);
  localparam logic [LARG_BIT-1:0] PEN_BIT = LARG_BIT'(LARG_COD - 1);
  localparam logic [LARG_COD-1:0] COD_LIM = LARG_COD'(COD_MAX);

  estado_t             estado, estado_prox;
  logic [LARG_COD:0]   palavra_prox;
  logic [LARG_BIT-1:0] contagem_bit, bit_prox, indice;
  logic                serial_prox, pv_prox, ci_prox;
  logic                tick, tick_antes;

  divisor_bit #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_divisor (
    .clk       (clk),
    .rst       (rst),
    .limpa     (estado == OCIOSO),
    .tick      (tick),
    .tick_antes(tick_antes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado          <= OCIOSO;
      palavra         <= '0;
      palavra_valida  <= 1'b0;
      codigo_invalido <= 1'b0;
      serial          <= 1'b1;
      ocupado         <= 1'b0;
      pronto          <= 1'b1;
      contagem_bit    <= '0;
    end else begin
      estado          <= estado_prox;
      palavra         <= palavra_prox;
      palavra_valida  <= pv_prox;
      codigo_invalido <= ci_prox;
      serial          <= serial_prox;
      ocupado         <= (estado_prox != OCIOSO);
      pronto          <= (estado_prox == OCIOSO);
      contagem_bit    <= bit_prox;
    end
  end

  always_comb begin
    estado_prox  = estado;
    palavra_prox = palavra;
    serial_prox  = serial;
    bit_prox     = contagem_bit;
    pv_prox      = 1'b0;
    ci_prox      = 1'b0;
    indice       = PEN_BIT - contagem_bit;
    unique case (estado)
      OCIOSO: begin
        serial_prox = 1'b1;
        if (valido && pronto) begin
          if (codigo <= COD_LIM) begin
            palavra_prox = {codigo, paridade_par(codigo) ^ injeta_erro};
            pv_prox      = 1'b1;
            estado_prox  = INICIO;
            serial_prox  = 1'b0;
            bit_prox     = '0;
          end else begin
            ci_prox = 1'b1;
          end
        end
      end
      INICIO: begin
        if (tick) begin
          estado_prox = DADOS;
          serial_prox = palavra[LARG_COD];
          bit_prox    = '0;
        end
      end
      DADOS: begin
        if (tick) begin
          if (contagem_bit == ULT_BIT) begin
            bit_prox    = '0;
            serial_prox = 1'b1;
            // with one cycle per bit the idle cycle alone forms the stop bit
            estado_prox = (CICLOS_POR_BIT == 1) ? OCIOSO : PARADA;
          end else begin
            bit_prox    = contagem_bit + 1'b1;
            serial_prox = palavra[indice];
          end
        end
      end
      PARADA: begin
        serial_prox = 1'b1;
        if (tick_antes) begin
          estado_prox = OCIOSO;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        serial_prox = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_transmissor_paridade.sv
// Bench for transmissor_paridade: vector table of codes, scoreboard of expected words,
// per-cycle frame check, back-to-back and mid-frame reset sequences.
module tb_transmissor_paridade;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] codigo;
  logic       valido;
  logic       injeta_erro;
  logic       pronto;
  logic [5:0] palavra;
  logic       palavra_valida;
  logic       codigo_invalido;
  logic       serial;
  logic       ocupado;

  int total = 0;
  int bad   = 0;
  logic [5:0] esperado[$];

  typedef struct {
    logic [4:0] cod;
    logic       inj;
    logic       ok;
    logic [5:0] word;
  } vetor_t;

  vetor_t tab[6];

  transmissor_paridade #(
    .LARG_COD      (5),
    .COD_MAX       (19),
    .CICLOS_POR_BIT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .codigo         (codigo),
    .valido         (valido),
    .injeta_erro    (injeta_erro),
    .pronto         (pronto),
    .palavra        (palavra),
    .palavra_valida (palavra_valida),
    .codigo_invalido(codigo_invalido),
    .serial         (serial),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] req);
    total++;
    if (atual !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, req, $time);
    end
  endtask

  // scoreboard: every palavra_valida pulse must carry the oldest pending word
  always @(negedge clk) begin
    if (!rst && palavra_valida) begin
      if (esperado.size() == 0) begin
        confere("sb_underflow", 32'(palavra), 32'hffff_ffff);
      end else begin
        confere("sb_palavra", 32'(palavra), 32'(esperado.pop_front()));
      end
    end
  end

  // called at the negedge right after the accept edge; ends at the negedge where pronto is back
  task automatic quadro(input logic [5:0] w);
    logic esp;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4)       esp = 1'b0;
      else if (k < 28) esp = w[5 - (k - 4) / 4];
      else             esp = 1'b1;
      confere($sformatf("serial_k%0d", k), 32'(serial), 32'(esp));
      confere($sformatf("pronto_k%0d", k), 32'(pronto), 32'(k == 31));
      if (k == 0 || k == 30 || k == 31)
        confere($sformatf("ocupado_k%0d", k), 32'(ocupado), 32'(k != 31));
    end
  endtask

  task automatic envia(input logic [4:0] c, input logic inj, input logic ok, input logic [5:0] w);
    @(negedge clk);
    codigo = c;
    injeta_erro = inj;
    valido = 1'b1;
    if (ok) esperado.push_back(w);
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    confere("pv_pulse", 32'(palavra_valida), 32'(ok));
    confere("inv_pulse", 32'(codigo_invalido), 32'(!ok));
    if (ok) begin
      quadro(w);
    end else begin
      confere("rej_pronto", 32'(pronto), 32'd1);
      confere("rej_serial", 32'(serial), 32'd1);
      confere("rej_palavra", 32'(palavra), 32'(w));
      @(negedge clk);
      confere("inv_one_cycle", 32'(codigo_invalido), 32'd0);
      confere("rej_serial2", 32'(serial), 32'd1);
    end
  endtask

  initial begin
    tab[0] = '{5'b00000, 1'b0, 1'b1, 6'b000000};
    tab[1] = '{5'b10011, 1'b0, 1'b1, 6'b100111};
    tab[2] = '{5'b10100, 1'b0, 1'b0, 6'b100111};
    tab[3] = '{5'b11111, 1'b0, 1'b0, 6'b100111};
    tab[4] = '{5'b01011, 1'b1, 1'b1, 6'b010110};
    tab[5] = '{5'b00001, 1'b0, 1'b1, 6'b000011};

    rst = 1'b1;
    codigo = '0;
    valido = 1'b0;
    injeta_erro = 1'b0;
    #12;
    confere("rst_pronto", 32'(pronto), 32'd1);
    confere("rst_serial", 32'(serial), 32'd1);
    confere("rst_palavra", 32'(palavra), 32'd0);
    confere("rst_ocupado", 32'(ocupado), 32'd0);
    confere("rst_pv", 32'(palavra_valida), 32'd0);
    confere("rst_inv", 32'(codigo_invalido), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      envia(tab[i].cod, tab[i].inj, tab[i].ok, tab[i].word);
    end

    // valido held high: second code accepted on the edge where pronto returns
    @(negedge clk);
    codigo = 5'd3;
    injeta_erro = 1'b0;
    valido = 1'b1;
    esperado.push_back(6'b000110);
    @(posedge clk);
    @(negedge clk);
    codigo = 5'd7;
    esperado.push_back(6'b001111);
    quadro(6'b000110);
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    confere("b2b_pv", 32'(palavra_valida), 32'd1);
    quadro(6'b001111);

    // code changes mid-frame must not leak into the transmitted word
    @(negedge clk);
    codigo = 5'd2;
    valido = 1'b1;
    esperado.push_back(6'b000101);
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    codigo = 5'd31;
    injeta_erro = 1'b1;
    quadro(6'b000101);
    confere("hold_palavra", 32'(palavra), 32'(6'b000101));
    injeta_erro = 1'b0;

    // reset during data bit 2 of code 17 (word 100010, bit 2 is 0)
    @(negedge clk);
    codigo = 5'd17;
    valido = 1'b1;
    esperado.push_back(6'b100010);
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    repeat (13) @(negedge clk);
    confere("pre_rst_serial", 32'(serial), 32'd0);
    confere("pre_rst_ocupado", 32'(ocupado), 32'd1);
    rst = 1'b1;
    #1;
    confere("arst_serial", 32'(serial), 32'd1);
    confere("arst_pronto", 32'(pronto), 32'd1);
    confere("arst_palavra", 32'(palavra), 32'd0);
    confere("arst_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    envia(5'd9, 1'b0, 1'b1, 6'b010010);

    repeat (2) @(negedge clk);
    confere("sb_empty", 32'(esperado.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
